rr_sel_arb: RTL

RR_SEL_ARB -- requirements
Module: rr_sel_arb

---
 rtl/pmux_pkg.sv | 22 ++
 rtl/rr_sel_arb_pick.sv | 26 ++
 rtl/rr_sel_arb.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pmux_pkg.sv
// Shared constants, state encoding and helpers for the round-robin select arbiter.
package pmux_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned PTR_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Convert a one-hot (or zero) vector to its bit index; zero maps to 0.
  function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_sel_arb_pick.sv
// rr_pick: first set request bit at or after a start pointer, wrapping high to low.
module rr_pick
  import pmux_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_c,
  output logic               o_found_c
);

  // Scan from the pointer upward; the 3-bit index wraps 7 -> 0 by itself.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    o_gnt_c   = '0;
    o_found_c = 1'b0;
    v_idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_idx = i_ptr + PTR_W'(k);
      if (!o_found_c && i_req[v_idx]) begin
        o_gnt_c[v_idx] = 1'b1;
        o_found_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arb.sv
// rr_sel_arb: 8-way round-robin arbiter that registers the winner's one-hot
// select and payload for a downstream pmux stage, with back-to-back re-arbitration.
// Optional macro RR_SEL_ARB_LOCK_EN adds lock_i to keep the current winner.
module rr_sel_arb
  import pmux_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [DATA_W-1:0]  data_0_i,
  input  logic [DATA_W-1:0]  data_1_i,
  input  logic [DATA_W-1:0]  data_2_i,
  input  logic [DATA_W-1:0]  data_3_i,
  input  logic [DATA_W-1:0]  data_4_i,
  input  logic [DATA_W-1:0]  data_5_i,
  input  logic [DATA_W-1:0]  data_6_i,
  input  logic [DATA_W-1:0]  data_7_i,
  input  logic               ready_i,
`ifdef RR_SEL_ARB_LOCK_EN
  input  logic               lock_i,
`endif
  output logic [NUM_REQ-1:0] grant_o,
  output logic [DATA_W-1:0]  q_o,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] ack_o
);

  state_e             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [DATA_W-1:0]  r_q, w_q_nxt;

  logic [DATA_W-1:0]  w_data [NUM_REQ];
  logic               w_lock;
  logic               w_hs;
  logic [PTR_W-1:0]   w_win_idx;
  logic [PTR_W-1:0]   w_ptr_hs;
  logic [PTR_W-1:0]   w_pick_ptr;
  logic [NUM_REQ-1:0] w_pick_req;
  logic [NUM_REQ-1:0] w_pick_gnt;
  logic               w_pick_found;
  logic [PTR_W-1:0]   w_pick_idx;

  assign w_data[0] = data_0_i;
  assign w_data[1] = data_1_i;
  assign w_data[2] = data_2_i;
  assign w_data[3] = data_3_i;
  assign w_data[4] = data_4_i;
  assign w_data[5] = data_5_i;
  assign w_data[6] = data_6_i;
  assign w_data[7] = data_7_i;

`ifdef RR_SEL_ARB_LOCK_EN
  assign w_lock = lock_i;
`else
  assign w_lock = 1'b0;
`endif

  // Handshake, and the pointer/mask used to re-arbitrate in the same cycle.
  assign w_hs       = (r_state == ST_HOLD) && ready_i;
  assign w_win_idx  = oh_to_idx(r_grant);
  assign w_ptr_hs   = w_lock ? r_ptr : (w_win_idx + PTR_W'(1));
  assign w_pick_ptr = w_hs ? w_ptr_hs : r_ptr;
  assign w_pick_req = (w_hs && !w_lock) ? (req_i & ~r_grant) : req_i;

  rr_pick u_pick (
    .i_req     (w_pick_req),
    .i_ptr     (w_pick_ptr),
    .o_gnt_c   (w_pick_gnt),
    .o_found_c (w_pick_found)
  );

  assign w_pick_idx = oh_to_idx(w_pick_gnt);

  // Next-state logic: grant from IDLE, hold until ready, chain or release on handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_q_nxt     = r_q;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_grant_nxt = w_pick_gnt;
          w_q_nxt     = w_data[w_pick_idx];
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ready_i) begin
          w_ptr_nxt = w_ptr_hs;
          if (w_pick_found) begin
            w_grant_nxt = w_pick_gnt;
            w_q_nxt     = w_data[w_pick_idx];
          end else begin
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, pointer and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_q     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_q     <= w_q_nxt;
    end
  end

  // ack pulses during the handshake cycle itself; suppressed while reset is applied.
  assign grant_o = r_grant;
  assign q_o     = r_q;
  assign valid_o = (r_state == ST_HOLD);
  assign ack_o   = (w_hs && rst_ni) ? r_grant : '0;

endmodule
